// File: rtl/aes_key_schedule_if.sv
// Key-load / round-key read bus between the cipher control and aes_key_schedule.
// MAX_NK sizes the key field and must match the engine's MAX_NK.
interface aes_key_schedule_if #(
    parameter int MAX_NK = 8
);
    logic                  start;
    logic [1:0]            key_len;
    logic [32*MAX_NK-1:0]  key;
    logic                  busy;
    logic                  done;
    logic                  key_err;
    logic [14:0]           round_ready;
    logic [3:0]            rk_addr;
    logic [127:0]          rk_data;
    logic                  rk_valid;

    modport master (
        output start, key_len, key, rk_addr,
        input  busy, done, key_err, round_ready, rk_data, rk_valid
    );

    modport slave (
        input  start, key_len, key, rk_addr,
        output busy, done, key_err, round_ready, rk_data, rk_valid
    );
endinterface

// File: rtl/aes_key_schedule.sv
// Sequential AES-128/192/256 key expansion, one word per clock, with a registered round-key read port.
// Optional macro AES_KEY_ZEROIZE_EN adds a zeroize input and a CLEAR state that wipes the store.
module aes_key_schedule #(
    parameter int MAX_NK = 8
) (
    input  logic clk,
    input  logic rst,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic zeroize,
`endif
    aes_key_schedule_if.slave bus
);
    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam int KW    = 32 * MAX_NK;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

`ifdef AES_KEY_ZEROIZE_EN
    typedef enum logic [1:0] {IDLE, EXPAND, CLEAR} state_t;
`else
    typedef enum logic {IDLE, EXPAND} state_t;
`endif
    state_t state, next_state;

    logic [KW-1:0] key_sh;
    logic [31:0]   window [8];
    logic [31:0]   store [DEPTH];
    logic [3:0]    nk, nr, nk_req;
    logic [5:0]    nw, idx, rd_base;
    logic [2:0]    wrap, nk_m1;
    logic [7:0]    rcon;
    logic          accept, reject, zero_hit, last_word, store_we, rd_ok;
    logic [31:0]   prev, far, sub_in, sub_out, temp, new_word, store_wdata;

    always_comb begin
        case (bus.key_len)
            2'b00:   nk_req = 4'd4;
            2'b01:   nk_req = 4'd6;
            default: nk_req = 4'd8;
        endcase
    end

    // window[0] is w[i-1], window[Nk-1] is w[i-Nk]; one S-box serves both SubWord cases
    always_comb begin
        nk_m1   = 3'(nk - 4'd1);
        prev    = window[0];
        far     = window[nk_m1];
        sub_in  = (wrap == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        sub_out = {sub_byte(sub_in[31:24]), sub_byte(sub_in[23:16]),
                   sub_byte(sub_in[15:8]),  sub_byte(sub_in[7:0])};
        if (wrap == 3'd0)
            temp = sub_out ^ {rcon, 24'h0};
        else if (nk == 4'd8 && wrap == 3'd4)
            temp = sub_out;
        else
            temp = prev;
        if (idx < {2'b00, nk})
            new_word = key_sh[KW-1 -: 32];
        else
            new_word = far ^ temp;
        last_word = (idx == nw - 6'd1);
        rd_base   = {bus.rk_addr, 2'b00};
        rd_ok     = (bus.rk_addr <= nr) && bus.round_ready[bus.rk_addr];
    end

    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        reject      = 1'b0;
        zero_hit    = 1'b0;
        store_we    = 1'b0;
        store_wdata = new_word;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.key_len != 2'b11 && int'(nk_req) <= MAX_NK) begin
                        accept     = 1'b1;
                        next_state = EXPAND;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            EXPAND: begin
                store_we = 1'b1;
                if (last_word) next_state = IDLE;
            end
`ifdef AES_KEY_ZEROIZE_EN
            CLEAR: begin
                store_we    = 1'b1;
                store_wdata = '0;
                if (idx == 6'(DEPTH - 1)) next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
`ifdef AES_KEY_ZEROIZE_EN
        if (zeroize) begin
            zero_hit   = 1'b1;
            accept     = 1'b0;
            reject     = 1'b0;
            next_state = CLEAR;
        end
`endif
        bus.busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Store, window and key shifter carry no reset: unreadable until round_ready is rebuilt
    always_ff @(posedge clk) begin
        if (accept)
            key_sh <= bus.key;
        else if (state == EXPAND)
            key_sh <= key_sh << 32;
        if (store_we) begin
            store[idx] <= store_wdata;
            window[0]  <= store_wdata;
            for (int unsigned k = 7; k > 0; k--) window[k] <= window[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.round_ready <= '0;
            bus.done        <= 1'b0;
            bus.key_err     <= 1'b0;
            bus.rk_valid    <= 1'b0;
            bus.rk_data     <= '0;
            idx             <= '0;
            wrap            <= '0;
            rcon            <= 8'h01;
            nk              <= 4'd4;
            nr              <= 4'd10;
            nw              <= 6'd44;
        end else begin
            bus.done    <= 1'b0;
            bus.key_err <= reject;
            if (zero_hit) begin
                bus.round_ready <= '0;
                idx             <= '0;
            end else if (accept) begin
                nk              <= nk_req;
                nr              <= nk_req + 4'd6;
                nw              <= {nk_req, 2'b00} + 6'd28;
                bus.round_ready <= '0;
                idx             <= '0;
                wrap            <= '0;
                rcon            <= 8'h01;
            end else if (state == EXPAND) begin
                idx  <= idx + 6'd1;
                wrap <= (wrap == nk_m1) ? 3'd0 : wrap + 3'd1;
                if (wrap == 3'd0 && idx >= {2'b00, nk})
                    rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                if (idx[1:0] == 2'b11) bus.round_ready[idx[5:2]] <= 1'b1;
                if (last_word) bus.done <= 1'b1;
            end
`ifdef AES_KEY_ZEROIZE_EN
            else if (state == CLEAR) begin
                idx <= idx + 6'd1;
            end
`endif
            bus.rk_valid <= rd_ok;
            bus.rk_data  <= rd_ok ? {store[rd_base], store[rd_base + 6'd1],
                                     store[rd_base + 6'd2], store[rd_base + 6'd3]} : '0;
        end
    end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: FIPS-197 round keys, latency, early reads,
// rejected starts, mid-run reset and (with AES_KEY_ZEROIZE_EN) zeroize.
module tb_aes_key_schedule;
    logic clk = 1'b0;
    logic rst;
`ifdef AES_KEY_ZEROIZE_EN
    logic zeroize;
`endif
    always #5 clk = ~clk;

    aes_key_schedule_if #(.MAX_NK(8)) bus();
    aes_key_schedule_if #(.MAX_NK(4)) bus4();

    aes_key_schedule #(.MAX_NK(8)) u_dut (
        .clk(clk),
        .rst(rst),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .bus(bus.slave)
    );

    aes_key_schedule #(.MAX_NK(4)) u_dut4 (
        .clk(clk),
        .rst(rst),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize(1'b0),
`endif
        .bus(bus4.slave)
    );

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                     128'hdeadbeefcafef00d0123456789abcdef};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                     64'hfeedface0badf00d};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] ALL  = {128{1'b1}};
    localparam logic [127:0] LOW  = 128'hffffffff;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] data;
        logic [127:0] mask;
        logic         valid;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        string        name;
        logic [1:0]   len;
        logic [255:0] key;
        int           lat;
        logic [3:0]   round;
        logic [127:0] data;
        logic [127:0] mask;
        logic         valid;
        logic [14:0]  rr;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [3:0] r, input logic [127:0] d,
                      input logic [127:0] m, input logic v);
        sb_t e;
        sb.push_back('{data: d, mask: m, valid: v});
        bus.rk_addr = r;
        @(posedge clk); #1;
        e = sb.pop_front();
        check({name, " data"}, bus.rk_data & e.mask, e.data & e.mask);
        check({name, " valid"}, 128'(bus.rk_valid), 128'(e.valid));
    endtask

    task automatic run(input logic [1:0] len, input logic [255:0] k, input logic [3:0] addr,
                       input int poke, output int lat, output int first_valid, output logic any_valid);
        bus.key_len = len;
        bus.key     = k;
        bus.rk_addr = addr;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy after start", 128'(bus.busy), 128'(1));
        lat = 0;
        first_valid = -1;
        any_valid = 1'b0;
        while (!bus.done && lat < 100) begin
            bus.start   = (lat == poke);
            bus.key_len = (lat == poke) ? 2'b10 : len;
            @(posedge clk); #1;
            lat++;
            if (bus.rk_valid && first_valid < 0) first_valid = lat;
            any_valid |= bus.rk_valid;
        end
        bus.start   = 1'b0;
        bus.key_len = len;
        check("busy at done", 128'(bus.busy), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, fv;
        logic av;
        int   cnt;
        logic saw_done;

        rst = 1'b1;
        bus.start = 1'b0;  bus.key_len = 2'b00;  bus.key = '0;  bus.rk_addr = 4'd0;
        bus4.start = 1'b0; bus4.key_len = 2'b00; bus4.key = '0; bus4.rk_addr = 4'd0;
`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        vecs[0] = '{"a128 r0",  2'd0, K128, 44, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, ALL, 1'b1, 15'h07ff};
        vecs[1] = '{"a128 r1",  2'd0, K128, 44, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, ALL, 1'b1, 15'h07ff};
        vecs[2] = '{"a128 r2",  2'd0, K128, 44, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f, ALL, 1'b1, 15'h07ff};
        vecs[3] = '{"a128 r10", 2'd0, K128, 44, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, ALL, 1'b1, 15'h07ff};
        vecs[4] = '{"a128 r11", 2'd0, K128, 44, 4'd11, 128'h0,                                ALL, 1'b0, 15'h07ff};
        vecs[5] = '{"a192 r1",  2'd1, K192, 52, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, ALL, 1'b1, 15'h1fff};
        vecs[6] = '{"a192 r12", 2'd1, K192, 52, 4'd12, 128'h01002202,                         LOW, 1'b1, 15'h1fff};
        vecs[7] = '{"a256 r2",  2'd2, K256, 60, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde, ALL, 1'b1, 15'h7fff};
        vecs[8] = '{"a256 r3",  2'd2, K256, 60, 4'd3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a, ALL, 1'b1, 15'h7fff};
        vecs[9] = '{"a256 r14", 2'd2, K256, 60, 4'd14, 128'h706c631e,                         LOW, 1'b1, 15'h7fff};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy",        128'(bus.busy),        128'(0));
        check("reset done",        128'(bus.done),        128'(0));
        check("reset key_err",     128'(bus.key_err),     128'(0));
        check("reset round_ready", 128'(bus.round_ready), 128'(0));
        check("reset rk_valid",    128'(bus.rk_valid),    128'(0));
        check("reset rk_data",     bus.rk_data,           128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run(vecs[i].len, vecs[i].key, 4'd0, -1, lat, fv, av);
            check({vecs[i].name, " latency"}, 128'(lat), 128'(vecs[i].lat));
            check({vecs[i].name, " round_ready"}, 128'(bus.round_ready), 128'(vecs[i].rr));
            rd(vecs[i].name, vecs[i].round, vecs[i].data, vecs[i].mask, vecs[i].valid);
        end

        // early read of round 2 while AES-128 expansion is still running
        run(2'd0, K128, 4'd2, -1, lat, fv, av);
        check("early rd first valid", 128'(fv), 128'(13));
        run(2'd0, K128, 4'd11, -1, lat, fv, av);
        check("rd r11 never valid", 128'(av), 128'(0));

        // start pulsed mid-run must be ignored
        run(2'd0, K128, 4'd0, 10, lat, fv, av);
        check("midrun start latency", 128'(lat), 128'(44));
        rd("midrun r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, ALL, 1'b1);

        bus.key_len = 2'b11;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("len11 key_err", 128'(bus.key_err), 128'(1));
        check("len11 busy",    128'(bus.busy),    128'(0));
        @(posedge clk); #1;
        check("len11 key_err pulse", 128'(bus.key_err), 128'(0));
        check("len11 busy stays",    128'(bus.busy),    128'(0));
        check("len11 round_ready",   128'(bus.round_ready), 128'(15'h07ff));
        rd("after err r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, ALL, 1'b1);

        bus4.key     = K128[255:128];
        bus4.key_len = 2'b10;
        bus4.start   = 1'b1;
        @(posedge clk); #1;
        check("nk4 len10 key_err", 128'(bus4.key_err), 128'(1));
        check("nk4 len10 busy",    128'(bus4.busy),    128'(0));
        bus4.key_len = 2'b01;
        @(posedge clk); #1;
        check("nk4 len01 key_err", 128'(bus4.key_err), 128'(1));
        check("nk4 len01 busy",    128'(bus4.busy),    128'(0));
        bus4.key_len = 2'b00;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        check("nk4 len00 key_err", 128'(bus4.key_err), 128'(0));
        check("nk4 len00 busy",    128'(bus4.busy),    128'(1));

        // reset 20 cycles into an AES-256 run
        bus.key_len = 2'b10;
        bus.key     = K256;
        bus.rk_addr = 4'd0;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("pre-reset rk_valid", 128'(bus.rk_valid), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst busy",        128'(bus.busy),        128'(0));
        check("midrst done",        128'(bus.done),        128'(0));
        check("midrst key_err",     128'(bus.key_err),     128'(0));
        check("midrst round_ready", 128'(bus.round_ready), 128'(0));
        check("midrst rk_valid",    128'(bus.rk_valid),    128'(0));
        check("midrst rk_data",     bus.rk_data,           128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        run(2'd2, K256, 4'd0, -1, lat, fv, av);
        check("post-reset latency", 128'(lat), 128'(60));
        rd("post-reset r14", 4'd14, 128'h706c631e, LOW, 1'b1);
        rd("post-reset r3", 4'd3, 128'ha8b09c1a93d194cdbe49846eb75d5b9a, ALL, 1'b1);

`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b1;
        @(posedge clk); #1;
        zeroize = 1'b0;
        check("zeroize round_ready", 128'(bus.round_ready), 128'(0));
        check("zeroize busy",        128'(bus.busy),        128'(1));
        cnt = 0;
        saw_done = 1'b0;
        while (bus.busy && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            saw_done |= bus.done;
        end
        check("zeroize clear cycles", 128'(cnt), 128'(60));
        check("zeroize no done",      128'(saw_done), 128'(0));
        for (int r = 0; r < 15; r++) begin
            rd("zeroized read", 4'(r), 128'(0), ALL, 1'b0);
        end
`else
        cnt = 0;
        saw_done = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
